prod_sum1_dot_seq: RTL and testbench

Sequencer that computes a dot product of a stream of A/B pairs on one shared product-sum datapath (SUM = A*B + C), with C fed from a registered accumulator. A start pulse loads an initial value and a pair count. The block then accepts one pair per cycle through a valid/ready handshake and returns the final sum through an output handshake. It sits between a stream source and the consumer that owns the DW02_prod_sum1-style multiply-add resource.

---
 rtl/prod_sum1_dot_seq_if.sv | 38 +++
 rtl/prod_sum1_dot_seq.sv | 103 ++++++++++
 tb/tb_prod_sum1_dot_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/prod_sum1_dot_seq_if.sv
// prod_sum1_dot_seq_if
//   Handshake and job-control bundle for the prod_sum1_dot_seq dot-product sequencer.
//   master : stream source / job controller / result consumer side
//   slave  : the sequencer itself
//   Job control : start, len, tc, init_C
//   Input pairs : in_valid, in_ready, in_A, in_B
//   Result      : out_valid, out_ready, out_sum
//   Status      : busy, count
interface prod_sum1_dot_seq_if #(
  parameter int A_width   = 5,
  parameter int B_width   = 5,
  parameter int SUM_width = 11,
  parameter int LEN_width = 4
);
  logic                 start;
  logic [LEN_width-1:0] len;
  logic                 tc;
  logic [SUM_width-1:0] init_C;
  logic                 in_valid;
  logic                 in_ready;
  logic [A_width-1:0]   in_A;
  logic [B_width-1:0]   in_B;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUM_width-1:0] out_sum;
  logic                 busy;
  logic [LEN_width-1:0] count;

  modport master (
    output start, len, tc, init_C, in_valid, in_A, in_B, out_ready,
    input  in_ready, out_valid, out_sum, busy, count
  );

  modport slave (
    input  start, len, tc, init_C, in_valid, in_A, in_B, out_ready,
    output in_ready, out_valid, out_sum, busy, count
  );
endinterface

// File: rtl/prod_sum1_dot_seq.sv
// prod_sum1_dot_seq
//   Dot-product sequencer around one multiply-add (SUM = A*B + C), with C taken
//   from a registered accumulator. A start in IDLE loads init_C, the pair count
//   and the signedness mode. Pairs are then accepted one per cycle via
//   in_valid/in_ready, and the final sum is offered via out_valid/out_ready.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : prod_sum1_dot_seq_if.slave (start/len/tc/init_C, input pair
//            handshake, result handshake, busy, count)
module prod_sum1_dot_seq #(
  parameter int A_width   = 5,
  parameter int B_width   = 5,
  parameter int SUM_width = 11,
  parameter int LEN_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  prod_sum1_dot_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SUM_width-1:0] acc;
  logic [LEN_width-1:0] rem;
  logic [LEN_width-1:0] cnt;
  logic                 tc_r;

  logic                 accept;
  logic [SUM_width-1:0] a_ext, b_ext, prod_sum;

  assign accept = bus.in_valid && (state_q == RUN);

  // Extending both operands to SUM_width before multiplying yields the
  // zero- or sign-extended product modulo 2^SUM_width directly.
  always_comb begin
    a_ext = {{(SUM_width-A_width){tc_r & bus.in_A[A_width-1]}}, bus.in_A};
    b_ext = {{(SUM_width-B_width){tc_r & bus.in_B[B_width-1]}}, bus.in_B};
    prod_sum = a_ext * b_ext + acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (rem == LEN_width'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      rem  <= '0;
      cnt  <= '0;
      tc_r <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        acc  <= bus.init_C;
        rem  <= bus.len;
        cnt  <= '0;
        tc_r <= bus.tc;
      end else if (accept) begin
        acc <= prod_sum;
        rem <= rem - LEN_width'(1);
        cnt <= cnt + LEN_width'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = acc;
  assign bus.count     = cnt;

endmodule

// File: tb/tb_prod_sum1_dot_seq.sv
module tb_prod_sum1_dot_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   accepts;

  always #5 clk = ~clk;

  prod_sum1_dot_seq_if #(.A_width(5), .B_width(5), .SUM_width(11), .LEN_width(4)) bus ();

  prod_sum1_dot_seq #(.A_width(5), .B_width(5), .SUM_width(11), .LEN_width(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic t, input logic [10:0] c, input logic [3:0] n);
    bus.start  = 1'b1;
    bus.tc     = t;
    bus.init_C = c;
    bus.len    = n;
    tick();
    bus.start  = 1'b0;
    bus.tc     = ~t;
    bus.init_C = 11'h555;
    bus.len    = 4'hf;
  endtask

  task automatic pair(input logic [4:0] a, input logic [4:0] b);
    bus.in_valid = 1'b1;
    bus.in_A     = a;
    bus.in_B     = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.tc = 1'b0; bus.init_C = '0;
    bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);

    // Unsigned: 5 + 12 + 14 + 961 = 992
    start_job(1'b0, 11'd5, 4'd3);
    chk("u_busy", bus.busy, 1);
    chk("u_in_ready", bus.in_ready, 1);
    chk("u_count0", bus.count, 0);
    pair(5'd3, 5'd4);
    pair(5'd2, 5'd7);
    chk("u_not_done_yet", bus.out_valid, 0);
    pair(5'd31, 5'd31);
    chk("u_out_valid", bus.out_valid, 1);
    chk("u_out_sum", bus.out_sum, 992);
    chk("u_count", bus.count, 3);
    chk("u_in_ready_done", bus.in_ready, 0);
    take();
    chk("u_busy_after", bus.busy, 0);
    chk("u_out_valid_after", bus.out_valid, 0);

    // Signed: 10 + (-1*3) + (-16*-16) = 263
    start_job(1'b1, 11'd10, 4'd2);
    pair(5'b11111, 5'd3);
    pair(5'b10000, 5'b10000);
    chk("s_out_valid", bus.out_valid, 1);
    chk("s_out_sum", bus.out_sum, 263);
    take();

    // Wrap: 2047 + 1 = 0 mod 2048
    start_job(1'b0, 11'd2047, 4'd1);
    pair(5'd1, 5'd1);
    chk("w_out_sum", bus.out_sum, 0);
    take();

    // Zero-length job
    start_job(1'b0, 11'd123, 4'd0);
    chk("z_out_valid", bus.out_valid, 1);
    chk("z_out_sum", bus.out_sum, 123);
    chk("z_in_ready", bus.in_ready, 0);
    take();
    chk("z_in_ready_after", bus.in_ready, 0);

    // Backpressure: in_valid 1,0,0,1,1 -> pairs (1,1),(2,2),(3,3) accepted = 14
    start_job(1'b0, 11'd0, 4'd3);
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 0 || i == 3 || i == 4);
      bus.in_A = (i == 0) ? 5'd1 : (i == 3) ? 5'd2 : (i == 4) ? 5'd3 : 5'd9;
      bus.in_B = bus.in_A;
      if (bus.in_valid && bus.in_ready) accepts++;
      tick();
      if (i == 2) chk("bp_count_mid", bus.count, 1);
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", accepts, 3);
    chk("bp_count", bus.count, 3);
    chk("bp_out_sum", bus.out_sum, 14);
    bus.start = 1'b1; bus.init_C = 11'd77; bus.len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_valid", bus.out_valid, 1);
      chk("bp_stall_sum", bus.out_sum, 14);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    chk("bp_start_ignored_busy", bus.busy, 0);
    chk("bp_start_ignored_valid", bus.out_valid, 0);

    // Reset mid-job after 2 of 4 pairs
    start_job(1'b0, 11'd50, 4'd4);
    pair(5'd1, 5'd1);
    pair(5'd1, 5'd1);
    chk("r_count2", bus.count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", bus.busy, 0);
    chk("r_count", bus.count, 0);
    chk("r_out_valid", bus.out_valid, 0);
    chk("r_out_sum", bus.out_sum, 0);

    start_job(1'b0, 11'd0, 4'd1);
    pair(5'd2, 5'd3);
    chk("r2_out_valid", bus.out_valid, 1);
    chk("r2_out_sum", bus.out_sum, 6);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
